// File: rtl/imm_extend_pipe.sv
// Immediate extension stage with an output FIFO.
// Each accepted immediate is extended (zero, sign, upper/LUI or branch) in the
// cycle it is accepted and written to the FIFO tail. Results leave the FIFO
// in acceptance order under a valid/ready handshake. in_ready and out_valid
// come straight from registers, so there is no combinational path from
// out_ready to in_ready.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  unextended,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] extended,
    output logic [15:0]      xfer_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Extend an immediate according to the 2-bit mode.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                    input logic [1:0]     m);
        logic [OUT_W-1:0] sx;
        sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (m)
            2'b00:   extend_imm = {{(OUT_W-IN_W){1'b0}}, imm};
            2'b01:   extend_imm = sx;
            2'b10:   extend_imm = {imm, {(OUT_W-IN_W){1'b0}}};
            2'b11:   extend_imm = {sx[OUT_W-3:0], 2'b00};
            default: extend_imm = {OUT_W{1'b0}};
        endcase
    endfunction

    logic [OUT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [15:0]      xfer_count_r;
    logic             push_s;
    logic             pop_s;

    assign push_s     = in_valid && in_ready_r;
    assign pop_s      = out_valid_r && out_ready;
    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign xfer_count = xfer_count_r;

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Show the head entry, masked to zero while the FIFO is empty.
    always_comb begin
        extended = {OUT_W{1'b0}};
        if (out_valid_r) begin
            extended = mem_r[rd_ptr_r];
        end else begin
            extended = {OUT_W{1'b0}};
        end
    end

    // Storage write at the tail; contents need no reset because of the mask.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= extend_imm(unextended, mode);
        end
    end

    // Pointers, occupancy, handshake flags and the pop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            xfer_count_r <= 16'h0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r     <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                xfer_count_r <= xfer_count_r + 16'h0001;
            end
            count_r     <= count_next_s;
            in_ready_r  <= (count_next_s < DEPTH_C);
            out_valid_r <= (count_next_s != {CNT_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe with default parameters.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] unextended;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] extended;
    logic [15:0] xfer_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int          exp_xfer;

    typedef struct {
        logic [1:0]  m;
        logic [15:0] u;
        logic [31:0] e;
    } vec_t;
    vec_t vecs[5];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .unextended(unextended), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .extended(extended), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    // Reference extension from arithmetic on the integer value.
    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] u);
        longint v;
        longint sx;
        v  = longint'(u);
        sx = (v >= 64'd32768) ? v + 64'd4294901760 : v;
        case (m)
            2'd0:    return 32'(v);
            2'd1:    return 32'(sx);
            2'd2:    return 32'(v * 64'd65536);
            default: return 32'(sx * 64'd4);
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: compare outputs with the model, then clock and update it.
    task automatic step(input logic iv, input logic [1:0] m, input logic [15:0] u,
                        input logic ordy);
        bit do_push;
        bit do_pop;
        in_valid = iv; mode = m; unextended = u; out_ready = ordy;
        chk("in_ready",   in_ready,   (exp_q.size() < 2) ? 1 : 0);
        chk("out_valid",  out_valid,  (exp_q.size() != 0) ? 1 : 0);
        chk("extended",   extended,   (exp_q.size() != 0) ? exp_q[0] : 0);
        chk("xfer_count", xfer_count, exp_xfer);
        do_push = iv && (exp_q.size() < 2);
        do_pop  = ordy && (exp_q.size() > 0);
        @(posedge clk); #1;
        if (do_pop) begin
            void'(exp_q.pop_front());
            exp_xfer = (exp_xfer + 1) % 65536;
        end
        if (do_push) exp_q.push_back(ref_ext(m, u));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        exp_xfer = 0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        unextended = 16'h0000; mode = 2'b00;
        vecs[0] = '{2'b01, 16'h000D, 32'h0000000D};
        vecs[1] = '{2'b01, 16'hCCCC, 32'hFFFFCCCC};
        vecs[2] = '{2'b00, 16'hCCCC, 32'h0000CCCC};
        vecs[3] = '{2'b10, 16'h1234, 32'h12340000};
        vecs[4] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
        @(posedge clk); #1;
        do_reset();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_extended",  extended,  0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_xfer",      xfer_count, 0);

        // Table of extension modes: push into empty FIFO, then pop
        for (int i = 0; i < 5; i++) begin
            step(1'b1, vecs[i].m, vecs[i].u, 1'b1);
            chk("vec_valid", out_valid, 1);
            chk("vec_ext",   extended,  vecs[i].e);
            step(1'b0, 2'b00, 16'h0000, 1'b1);
            if (i == 0) chk("vec0_xfer", xfer_count, 1);
        end
        chk("table_xfer", xfer_count, 5);

        // Backpressure and full behaviour
        step(1'b1, 2'b00, 16'h0001, 1'b0);
        step(1'b1, 2'b00, 16'h0002, 1'b0);
        chk("full_in_ready", in_ready, 0);
        step(1'b1, 2'b00, 16'h0003, 1'b0);
        step(1'b1, 2'b00, 16'h0003, 1'b1);
        chk("bp_head2", extended, 32'h00000002);
        chk("bp_in_ready_after_pop", in_ready, 1);
        step(1'b0, 2'b00, 16'h0000, 1'b1);
        chk("bp_empty", out_valid, 0);

        // Simultaneous push/pop at count 1
        do_reset();
        step(1'b1, 2'b01, 16'h0100, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b01, 16'($urandom), 1'b1);
        end
        chk("sim_xfer", xfer_count, 8);
        chk("sim_count1", out_valid && in_ready, 1);
        step(1'b0, 2'b00, 16'h0000, 1'b1);

        // Reset mid-stream with two entries buffered and a handshake pending
        step(1'b1, 2'b00, 16'h0005, 1'b0);
        step(1'b1, 2'b00, 16'h0006, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1;
        do_reset();
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_extended",  extended,  0);
        chk("mrst_in_ready",  in_ready,  1);
        chk("mrst_xfer",      xfer_count, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 2'($urandom), 16'($urandom), 1'($urandom));
        end

        // xfer_count wrap: one entry in flight, push and pop every cycle
        do_reset();
        step(1'b1, 2'b00, 16'h0007, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        chk("xfer_ffff", xfer_count, 16'hFFFF);
        @(posedge clk); #1;
        chk("xfer_wrap", xfer_count, 16'h0000);
        in_valid = 1'b0; out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
